// File: rtl/bram_req_adapter.sv
// Valid/ready request front end for a single BRAM port in master role.
// Issues one access per cycle and returns in-order responses through a 3-entry FIFO.
module bram_req_adapter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int ID_WIDTH   = 4
) (
   input  logic                    Clk_CI,
   input  logic                    Rst_RI,
   input  logic                    Req_Valid_SI,
   output logic                    Req_Ready_SO,
   input  logic                    Req_Write_SI,
   input  logic [ADDR_WIDTH-1:0]   Req_Addr_DI,
   input  logic [DATA_WIDTH-1:0]   Req_Wdata_DI,
   input  logic [DATA_WIDTH/8-1:0] Req_Strb_DI,
   input  logic [ID_WIDTH-1:0]     Req_Id_DI,
   output logic                    Resp_Valid_SO,
   input  logic                    Resp_Ready_SI,
   output logic                    Resp_Write_SO,
   output logic [ID_WIDTH-1:0]     Resp_Id_DO,
   output logic [DATA_WIDTH-1:0]   Resp_Rdata_DO,
   output logic                    Bram_Clk_CO,
   output logic                    Bram_Rst_RO,
   output logic                    Bram_En_SO,
   output logic [ADDR_WIDTH-1:0]   Bram_Addr_SO,
   output logic [DATA_WIDTH-1:0]   Bram_Wr_DO,
   output logic [DATA_WIDTH/8-1:0] Bram_WrEn_SO,
   input  logic [DATA_WIDTH-1:0]   Bram_Rd_DI
);

   localparam int STRB_WIDTH  = DATA_WIDTH / 8;
   localparam int OFFS        = $clog2(STRB_WIDTH);
   localparam int ENTRY_WIDTH = 1 + ID_WIDTH + DATA_WIDTH;
   localparam int DEPTH       = 3;
   localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'((1 << OFFS) - 1);

   logic                   accept;
   logic                   push;
   logic                   pop;
   logic [1:0]             occ;

   logic                   inflight_reg;
   logic                   inflight_write_reg;
   logic [ID_WIDTH-1:0]    inflight_id_reg;

   logic [1:0]             count_reg, count_next;
   logic [1:0]             wr_ptr_reg, wr_ptr_next;
   logic [1:0]             rd_ptr_reg, rd_ptr_next;

   logic [ENTRY_WIDTH-1:0] fifo_mem [DEPTH];
   logic [ENTRY_WIDTH-1:0] push_entry;
   logic [ENTRY_WIDTH-1:0] head_entry;

   function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
      return (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
   endfunction

   assign Bram_Clk_CO = Clk_CI;
   assign Bram_Rst_RO = Rst_RI;

   // Credit counts the in-flight access so the BRAM read always has a FIFO slot.
   assign occ          = count_reg + {1'b0, inflight_reg};
   assign Req_Ready_SO = !Rst_RI && (occ < 2'd3);
   assign accept       = Req_Valid_SI && Req_Ready_SO;

   assign push = inflight_reg;
   assign pop  = Resp_Valid_SO && Resp_Ready_SI;

   always_comb begin
      Bram_En_SO   = 1'b0;
      Bram_Addr_SO = '0;
      Bram_Wr_DO   = '0;
      Bram_WrEn_SO = '0;
      if (accept) begin
         Bram_En_SO   = 1'b1;
         Bram_Addr_SO = Req_Addr_DI & ~LOW_MASK;
         Bram_Wr_DO   = Req_Wdata_DI;
         Bram_WrEn_SO = Req_Write_SI ? Req_Strb_DI : '0;
      end
   end

   assign push_entry = {inflight_write_reg, inflight_id_reg,
                        inflight_write_reg ? {DATA_WIDTH{1'b0}} : Bram_Rd_DI};

   always_comb begin
      count_next  = count_reg;
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      if (push) begin
         wr_ptr_next = ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
         rd_ptr_next = ptr_inc(rd_ptr_reg);
      end
      case ({push, pop})
         2'b10:   count_next = count_reg + 2'd1;
         2'b01:   count_next = count_reg - 2'd1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge Clk_CI) begin
      if (Rst_RI) begin
         inflight_reg       <= 1'b0;
         inflight_write_reg <= 1'b0;
         inflight_id_reg    <= '0;
         count_reg          <= 2'd0;
         wr_ptr_reg         <= 2'd0;
         rd_ptr_reg         <= 2'd0;
      end else begin
         inflight_reg <= accept;
         count_reg    <= count_next;
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
         if (accept) begin
            inflight_write_reg <= Req_Write_SI;
            inflight_id_reg    <= Req_Id_DI;
         end
      end
   end

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge Clk_CI) begin
         if (push && (wr_ptr_reg == 2'(gi))) begin
            fifo_mem[gi] <= push_entry;
         end
      end
   end

   always_comb begin
      case (rd_ptr_reg)
         2'd1:    head_entry = fifo_mem[1];
         2'd2:    head_entry = fifo_mem[2];
         default: head_entry = fifo_mem[0];
      endcase
   end

   // Payload is gated by valid so an empty FIFO presents all-zero responses.
   assign Resp_Valid_SO = (count_reg != 2'd0);
   assign Resp_Write_SO = Resp_Valid_SO & head_entry[ENTRY_WIDTH-1];
   assign Resp_Id_DO    = Resp_Valid_SO ? head_entry[DATA_WIDTH +: ID_WIDTH] : '0;
   assign Resp_Rdata_DO = Resp_Valid_SO ? head_entry[DATA_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_bram_req_adapter.sv
// Directed bench for bram_req_adapter with a behavioural BRAM and an in-order
// response scoreboard fed at request acceptance.
module tb_bram_req_adapter;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_strb;
   logic [3:0]  req_id;
   logic        resp_valid;
   logic        resp_ready;
   logic        resp_write;
   logic [3:0]  resp_id;
   logic [31:0] resp_rdata;
   logic        bram_clk;
   logic        bram_rst;
   logic        bram_en;
   logic [31:0] bram_addr;
   logic [31:0] bram_wr;
   logic [3:0]  bram_wren;
   logic [31:0] bram_rd;

   int          n_checks = 0;
   int          n_fails  = 0;
   int          resp_cnt = 0;
   int          cnt_snap;

   logic [36:0] exp_q [$];
   logic [31:0] mem    [0:63];
   logic [31:0] shadow [0:63];
   logic        init_mem;

   bram_req_adapter #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(32),
      .ID_WIDTH  (4)
   ) dut (
      .Clk_CI       (clk),
      .Rst_RI       (rst),
      .Req_Valid_SI (req_valid),
      .Req_Ready_SO (req_ready),
      .Req_Write_SI (req_write),
      .Req_Addr_DI  (req_addr),
      .Req_Wdata_DI (req_wdata),
      .Req_Strb_DI  (req_strb),
      .Req_Id_DI    (req_id),
      .Resp_Valid_SO(resp_valid),
      .Resp_Ready_SI(resp_ready),
      .Resp_Write_SO(resp_write),
      .Resp_Id_DO   (resp_id),
      .Resp_Rdata_DO(resp_rdata),
      .Bram_Clk_CO  (bram_clk),
      .Bram_Rst_RO  (bram_rst),
      .Bram_En_SO   (bram_en),
      .Bram_Addr_SO (bram_addr),
      .Bram_Wr_DO   (bram_wr),
      .Bram_WrEn_SO (bram_wren),
      .Bram_Rd_DI   (bram_rd)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] init_word(input int i);
      if (i == 4) return 32'hDEAD_BEEF;
      if (i == 8) return 32'hFFFF_FFFF;
      return 32'h1000_0000 + 32'(i) * 32'h0101_0003;
   endfunction

   // Behavioural BRAM: one-cycle registered read, byte-enabled write
   always @(posedge clk) begin
      if (init_mem) begin
         for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      end else if (bram_en) begin
         for (int b = 0; b < 4; b++)
            if (bram_wren[b]) mem[bram_addr[7:2]][8*b +: 8] <= bram_wr[8*b +: 8];
         bram_rd <= mem[bram_addr[7:2]];
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Response monitor: pops the scoreboard on every handshake, checks hold stability
   logic [36:0] held;
   logic        hold_v = 1'b0;
   always @(negedge clk) begin
      logic [36:0] obs;
      logic [36:0] exp;
      if (rst) begin
         hold_v = 1'b0;
      end else if (resp_valid) begin
         obs = {resp_write, resp_id, resp_rdata};
         if (hold_v) check("resp_stable", 64'(obs), 64'(held));
         if (resp_ready) begin
            if (exp_q.size() == 0) begin
               check("resp_unexpected", 64'(resp_valid), 64'(0));
            end else begin
               exp = exp_q.pop_front();
               check("resp_payload", 64'(obs), 64'(exp));
               $display("resp: write=%0d id=%0h rdata=%08h", resp_write, resp_id, resp_rdata);
               resp_cnt++;
            end
            hold_v = 1'b0;
         end else begin
            held   = obs;
            hold_v = 1'b1;
         end
      end
   end

   // Presents a request at posedge+1 and returns at posedge+1 after it was accepted
   task automatic drive_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic [3:0] id, input int max_wait);
      int          waited = 0;
      logic [5:0]  idx;
      logic [36:0] exp;
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wdata;
      req_strb  = strb;
      req_id    = id;
      @(negedge clk);
      while (!req_ready && waited < max_wait) begin
         waited++;
         @(negedge clk);
      end
      check("req_ready", 64'(req_ready), 64'(1));
      if (req_ready) begin
         check("bram_en", 64'(bram_en), 64'(1));
         check("bram_addr", 64'(bram_addr), 64'(addr & 32'hFFFF_FFFC));
         check("bram_wren", 64'(bram_wren), 64'(wr ? strb : 4'b0000));
         if (wr) check("bram_wr", 64'(bram_wr), 64'(wdata));
         idx = addr[7:2];
         if (wr) begin
            exp = {1'b1, id, 32'h0};
            for (int b = 0; b < 4; b++)
               if (strb[b]) shadow[idx][8*b +: 8] = wdata[8*b +: 8];
         end else begin
            exp = {1'b0, id, shadow[idx]};
         end
         exp_q.push_back(exp);
         $display("req: write=%0d addr=%08h id=%0h", wr, addr, id);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int max_cycles);
      int n = 0;
      while (exp_q.size() != 0 && n < max_cycles) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_empty", 64'(exp_q.size()), 64'(0));
   endtask

   initial begin
      rst        = 1'b1;
      init_mem   = 1'b1;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      req_strb   = '0;
      req_id     = '0;
      resp_ready = 1'b1;
      for (int i = 0; i < 64; i++) shadow[i] = init_word(i);

      // Reset state
      @(posedge clk);
      @(posedge clk);
      #1;
      init_mem = 1'b0;
      @(negedge clk);
      check("rst_req_ready", 64'(req_ready), 64'(0));
      check("rst_bram_en", 64'(bram_en), 64'(0));
      check("rst_bram_wren", 64'(bram_wren), 64'(0));
      check("rst_resp_valid", 64'(resp_valid), 64'(0));
      check("rst_resp_write", 64'(resp_write), 64'(0));
      check("rst_resp_id", 64'(resp_id), 64'(0));
      check("rst_resp_rdata", 64'(resp_rdata), 64'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("first_ready", 64'(req_ready), 64'(1));
      @(posedge clk);
      #1;

      // Single read with 2-cycle latency
      drive_req(1'b0, 32'h10, 32'h0, 4'h0, 4'h3, 0);
      req_valid = 1'b0;
      @(negedge clk);
      check("single_en_one_cycle", 64'(bram_en), 64'(0));
      check("single_valid_t1", 64'(resp_valid), 64'(0));
      @(posedge clk);
      #1;
      @(negedge clk);
      check("single_valid_t2", 64'(resp_valid), 64'(1));
      check("single_rdata", 64'(resp_rdata), 64'(32'hDEAD_BEEF));
      check("single_id", 64'(resp_id), 64'(3));
      check("single_write", 64'(resp_write), 64'(0));
      @(posedge clk);
      #1;
      drain(5);

      // Byte write and read-back
      drive_req(1'b1, 32'h20, 32'h1122_3344, 4'b0101, 4'h5, 0);
      req_valid = 1'b0;
      drain(5);
      drive_req(1'b0, 32'h20, 32'h0, 4'h0, 4'h6, 0);
      req_valid = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("bytewrite_readback", 64'(resp_rdata), 64'(32'hFF22_FF44));
      @(posedge clk);
      #1;
      drain(5);

      // Zero-strobe write still responds
      drive_req(1'b1, 32'h24, 32'hCAFE_F00D, 4'b0000, 4'h7, 0);
      req_valid = 1'b0;
      drain(5);

      // Misaligned read
      drive_req(1'b0, 32'h13, 32'h0, 4'h0, 4'h9, 0);
      req_valid = 1'b0;
      drain(5);

      // Back-to-back throughput
      cnt_snap = resp_cnt;
      for (int i = 0; i < 16; i++)
         drive_req(1'b0, 32'(i * 4), 32'h0, 4'h0, 4'(i), 0);
      req_valid = 1'b0;
      drain(10);
      check("throughput_count", 64'(resp_cnt - cnt_snap), 64'(16));

      // Backpressure: three accepts then stall
      cnt_snap   = resp_cnt;
      resp_ready = 1'b0;
      drive_req(1'b0, 32'h04, 32'h0, 4'h0, 4'h1, 0);
      drive_req(1'b1, 32'h28, 32'hA5A5_5A5A, 4'b1111, 4'h2, 0);
      drive_req(1'b0, 32'h28, 32'h0, 4'h0, 4'h3, 0);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 32'h30;
      req_id    = 4'hC;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_stalled", 64'(req_ready), 64'(0));
      end
      @(posedge clk);
      #1;
      resp_ready = 1'b1;
      @(negedge clk);
      check("bp_ready_before_pop", 64'(req_ready), 64'(0));
      @(posedge clk);
      #1;
      drive_req(1'b0, 32'h30, 32'h0, 4'h0, 4'hC, 0);
      req_valid = 1'b0;
      drain(10);
      check("bp_count", 64'(resp_cnt - cnt_snap), 64'(4));

      // Reset with two buffered and one in flight
      resp_ready = 1'b0;
      drive_req(1'b0, 32'h08, 32'h0, 4'h0, 4'h7, 0);
      drive_req(1'b0, 32'h0C, 32'h0, 4'h0, 4'h8, 0);
      drive_req(1'b0, 32'h14, 32'h0, 4'h0, 4'h9, 0);
      req_valid = 1'b0;
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("mid_rst_ready", 64'(req_ready), 64'(0));
      check("mid_rst_en", 64'(bram_en), 64'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_resp_valid", 64'(resp_valid), 64'(0));
      check("mid_rst_resp_write", 64'(resp_write), 64'(0));
      check("mid_rst_resp_id", 64'(resp_id), 64'(0));
      check("mid_rst_resp_rdata", 64'(resp_rdata), 64'(0));
      check("mid_rst_ready_back", 64'(req_ready), 64'(1));
      @(posedge clk);
      #1;
      resp_ready = 1'b1;
      cnt_snap   = resp_cnt;
      repeat (5) @(posedge clk);
      #1;
      check("no_stale_resp", 64'(resp_cnt - cnt_snap), 64'(0));
      drive_req(1'b0, 32'h10, 32'h0, 4'h0, 4'hA, 0);
      req_valid = 1'b0;
      @(negedge clk);
      check("fresh_valid_t1", 64'(resp_valid), 64'(0));
      @(posedge clk);
      #1;
      @(negedge clk);
      check("fresh_valid_t2", 64'(resp_valid), 64'(1));
      check("fresh_rdata", 64'(resp_rdata), 64'(32'hDEAD_BEEF));
      @(posedge clk);
      #1;
      drain(5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
